quiz_round_ctrl: RTL and testbench

Round sequencer for the two-player quiz datapath. Arms each question, arbitrates the two buzzers, times the answer window and collects the judge's verdict. Delivers one scoring event per question to the scoreboard as a single-cycle `ready` pulse with `check1`/`check2`. Sits between the player buzzer inputs and the score/problem-counter block, and stops the game after the last question.

---
 rtl/quiz_round_ctrl_pkg.sv | 26 ++
 rtl/quiz_round_ctrl_if.sv | 38 +++
 rtl/quiz_round_ctrl_buzz_arbiter.sv | 42 ++++
 rtl/quiz_round_ctrl.sv | 153 +++++++++++++++
 tb/tb_quiz_round_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/quiz_round_ctrl_pkg.sv
// quiz_pkg: shared types and constants for the quiz round sequencer.
// Holds the round FSM state enum, the owner encodings and the default
// cycle counts used as parameter defaults by quiz_round_ctrl.
package quiz_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_OPEN   = 3'd2,
        ST_ANSWER = 3'd3,
        ST_SCORE  = 3'd4,
        ST_DONE   = 3'd5
    } round_state_t;

    // Owner encoding doubles as the one-hot grant {b, a} from the arbiter.
    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_A    = 2'b01;
    localparam logic [1:0] OWNER_B    = 2'b10;

    localparam int DEF_ARM_CYCLES    = 16;
    localparam int DEF_OPEN_CYCLES   = 1000;
    localparam int DEF_ANSWER_CYCLES = 500;
    localparam int DEF_NUM_PROBLEMS  = 8;
    localparam int DEF_TIMER_W       = 16;

endpackage

// File: rtl/quiz_round_ctrl_if.sv
// quiz_round_ctrl_if: player/judge/scoreboard signal bundle of the quiz
// round sequencer. The slave modport is the sequencer, the master modport
// is the surrounding game logic (buzzers, judge, scoreboard).
//
// Scoring handshake: ready is a one-cycle strobe with no back-pressure.
// check1/check2 are valid only in the cycle ready=1, at most one is set,
// and the scoreboard must consume the event in that same cycle.
interface quiz_round_ctrl_if #(
    parameter int TIMER_W = 16
);
    import quiz_pkg::*;

    logic               start;
    logic               buzz_a;
    logic               buzz_b;
    logic               answer_valid;
    logic               answer_correct;
    logic [2:0]         problem;
    logic               check1;
    logic               check2;
    logic               ready;
    logic [1:0]         owner;
    logic [TIMER_W-1:0] timer;
    logic               busy;
    logic               game_over;
    round_state_t       state;

    modport master (
        output start, buzz_a, buzz_b, answer_valid, answer_correct, problem,
        input  check1, check2, ready, owner, timer, busy, game_over, state
    );

    modport slave (
        input  start, buzz_a, buzz_b, answer_valid, answer_correct, problem,
        output check1, check2, ready, owner, timer, busy, game_over, state
    );

endinterface

// File: rtl/quiz_round_ctrl_buzz_arbiter.sv
// buzz_arbiter: two-player buzzer arbiter with lockout masks.
// A single eligible request wins outright; a same-cycle tie goes to the
// priority pointer, which flips after each tie when flip_on_tie=1 and
// stays on player A (fixed priority) when flip_on_tie=0.
module buzz_arbiter (
    input  logic       clk,
    input  logic       greset,
    input  logic       en,
    input  logic       flip_on_tie,
    input  logic [1:0] req,
    input  logic [1:0] lock,
    output logic [1:0] grant
);

    logic       prio_b;
    logic [1:0] elig;
    logic       tie;

    // Mask locked players and resolve ties with the pointer.
    always_comb begin
        elig  = req & ~lock;
        tie   = elig[0] & elig[1];
        grant = 2'b00;
        if (en) begin
            if (tie) begin
                grant = prio_b ? 2'b10 : 2'b01;
            end else begin
                grant = elig;
            end
        end
    end

    // Priority pointer: starts at A, flips only on a granted tie.
    always_ff @(posedge clk) begin
        if (greset) begin
            prio_b <= 1'b0;
        end else if (en && tie && flip_on_tie) begin
            prio_b <= ~prio_b;
        end
    end

endmodule

// File: rtl/quiz_round_ctrl.sv
// quiz_round_ctrl: round sequencer for the two-player quiz datapath.
// Arms each question, arbitrates the buzzers, times the answer window and
// emits one scoring strobe per question. Stops after the last problem.
// Optional feature macro QUIZ_FALSE_START_EN: a buzz during ARM locks that
// player out for the rest of the round.
module quiz_round_ctrl
    import quiz_pkg::*;
#(
    parameter int ARM_CYCLES    = DEF_ARM_CYCLES,
    parameter int OPEN_CYCLES   = DEF_OPEN_CYCLES,
    parameter int ANSWER_CYCLES = DEF_ANSWER_CYCLES,
    parameter int NUM_PROBLEMS  = DEF_NUM_PROBLEMS,
    parameter int TIMER_W       = DEF_TIMER_W
) (
    input  logic             clk,
    input  logic             greset,
    quiz_round_ctrl_if.slave bus
);

    localparam logic [TIMER_W-1:0] ARM_LOAD  = TIMER_W'(ARM_CYCLES - 1);
    localparam logic [TIMER_W-1:0] OPEN_LOAD = TIMER_W'(OPEN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] ANS_LOAD  = TIMER_W'(ANSWER_CYCLES - 1);
    localparam logic [2:0]         LAST_PROB = 3'(NUM_PROBLEMS - 1);

    round_state_t       state;
    logic [TIMER_W-1:0] timer;
    logic [1:0]         owner;
    logic               lock_a;
    logic               lock_b;
    logic               ready;
    logic               check1;
    logic               check2;
    logic [1:0]         grant;
    logic               timer_zero;
    logic               other_locked;
    logic [TIMER_W-1:0] timer_dec;

    buzz_arbiter u_arb (
        .clk         (clk),
        .greset      (greset),
        .en          (state == ST_OPEN),
        .flip_on_tie (1'b1),
        .req         ({bus.buzz_b, bus.buzz_a}),
        .lock        ({lock_b, lock_a}),
        .grant       (grant)
    );

    // Timer helpers: saturating decrement and the opponent's lockout.
    always_comb begin
        timer_zero   = (timer == '0);
        timer_dec    = timer_zero ? '0 : timer - TIMER_W'(1);
        other_locked = (owner == OWNER_A) ? lock_b : lock_a;
    end

    // Round FSM with shared down-counter, lockouts and scoring strobe.
    always_ff @(posedge clk) begin
        if (greset) begin
            state  <= ST_IDLE;
            timer  <= '0;
            owner  <= OWNER_NONE;
            lock_a <= 1'b0;
            lock_b <= 1'b0;
            ready  <= 1'b0;
            check1 <= 1'b0;
            check2 <= 1'b0;
        end else begin
            ready  <= 1'b0;
            check1 <= 1'b0;
            check2 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        timer  <= ARM_LOAD;
                        lock_a <= 1'b0;
                        lock_b <= 1'b0;
                        state  <= ST_ARM;
                    end
                end
                ST_ARM: begin
`ifdef QUIZ_FALSE_START_EN
                    if (bus.buzz_a) lock_a <= 1'b1;
                    if (bus.buzz_b) lock_b <= 1'b1;
`endif
                    if (timer_zero) begin
                        timer <= OPEN_LOAD;
                        state <= ST_OPEN;
                    end else begin
                        timer <= timer_dec;
                    end
                end
                ST_OPEN: begin
                    if (grant != 2'b00) begin
                        owner <= grant;
                        timer <= ANS_LOAD;
                        state <= ST_ANSWER;
                    end else if (timer_zero) begin
                        ready <= 1'b1;
                        state <= ST_SCORE;
                    end else begin
                        timer <= timer_dec;
                    end
                end
                ST_ANSWER: begin
                    if (bus.answer_valid && bus.answer_correct) begin
                        ready  <= 1'b1;
                        check1 <= (owner == OWNER_A);
                        check2 <= (owner == OWNER_B);
                        timer  <= '0;
                        state  <= ST_SCORE;
                    end else if (bus.answer_valid || timer_zero) begin
                        // Wrong or late answer: lock the holder, maybe rebound.
                        if (owner == OWNER_A) lock_a <= 1'b1;
                        if (owner == OWNER_B) lock_b <= 1'b1;
                        owner <= OWNER_NONE;
                        if (!other_locked) begin
                            timer <= OPEN_LOAD;
                            state <= ST_OPEN;
                        end else begin
                            ready <= 1'b1;
                            timer <= '0;
                            state <= ST_SCORE;
                        end
                    end else begin
                        timer <= timer_dec;
                    end
                end
                ST_SCORE: begin
                    owner <= OWNER_NONE;
                    state <= (bus.problem == LAST_PROB) ? ST_DONE : ST_IDLE;
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Drive the bundle from registered state.
    always_comb begin
        bus.state     = state;
        bus.timer     = timer;
        bus.owner     = owner;
        bus.ready     = ready;
        bus.check1    = check1;
        bus.check2    = check2;
        bus.busy      = (state != ST_IDLE) && (state != ST_DONE);
        bus.game_over = (state == ST_DONE);
    end

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// tb_quiz_round_ctrl: directed bench for quiz_round_ctrl with a scoring
// queue. Define QUIZ_FALSE_START_EN for both RTL and bench to cover the
// false-start build.
module tb_quiz_round_ctrl;
    import quiz_pkg::*;

    localparam int ARM_C  = 16;
    localparam int OPEN_C = 40;
    localparam int ANS_C  = 20;
    localparam int NPROB  = 8;
    localparam int TW     = 16;

    logic clk;
    logic greset;
    int   vecs = 0;
    int   errs = 0;
    int   took;
    logic [1:0] exp_q[$];

    quiz_round_ctrl_if #(.TIMER_W(TW)) bus ();

    quiz_round_ctrl #(
        .ARM_CYCLES    (ARM_C),
        .OPEN_CYCLES   (OPEN_C),
        .ANSWER_CYCLES (ANS_C),
        .NUM_PROBLEMS  (NPROB),
        .TIMER_W       (TW)
    ) u_dut (
        .clk    (clk),
        .greset (greset),
        .bus    (bus)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(bus.ready), 0);
        chk({tag, "_checks"}, 32'({bus.check1, bus.check2}), 0);
        chk({tag, "_owner"}, 32'(bus.owner), 0);
        chk({tag, "_timer"}, 32'(bus.timer), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_game_over"}, 32'(bus.game_over), 0);
        chk({tag, "_state"}, 32'(bus.state), 32'(ST_IDLE));
    endtask

    // Pulse start, optionally poke a stray verdict / A buzz in the first ARM cycle.
    task automatic start_round(input logic [2:0] p, input bit junk_verdict, input bit false_a);
        bus.problem = p;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("arm_state", 32'(bus.state), 32'(ST_ARM));
        chk("arm_timer", 32'(bus.timer), ARM_C - 1);
        bus.answer_valid   = junk_verdict;
        bus.answer_correct = junk_verdict;
        bus.buzz_a         = false_a;
        step();
        bus.answer_valid   = 1'b0;
        bus.answer_correct = 1'b0;
        bus.buzz_a         = 1'b0;
        chk("arm_hold", 32'(bus.state), 32'(ST_ARM));
        repeat (ARM_C - 1) step();
        chk("open_state", 32'(bus.state), 32'(ST_OPEN));
        chk("open_timer", 32'(bus.timer), OPEN_C - 1);
    endtask

    task automatic buzz(input logic a, input logic b);
        bus.buzz_a = a;
        bus.buzz_b = b;
        step();
        bus.buzz_a = 1'b0;
        bus.buzz_b = 1'b0;
    endtask

    // Wait (bounded) for the scoring strobe, pop and compare, then check it drops.
    task automatic wait_score(input string tag, input int max_cyc, output int lat);
        logic [1:0] e;
        lat = -1;
        for (int i = 1; i <= max_cyc; i++) begin
            step();
            bus.answer_valid   = 1'b0;
            bus.answer_correct = 1'b0;
            if (bus.ready === 1'b1) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) begin
            chk({tag, "_ready_timeout"}, 32'(bus.ready), 1);
        end else if (exp_q.size() == 0) begin
            chk({tag, "_unexpected_ready"}, 32'(bus.ready), 0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_checks"}, 32'({bus.check1, bus.check2}), 32'(e));
        end
        step();
        chk({tag, "_ready_drop"}, 32'(bus.ready), 0);
        chk({tag, "_owner_clear"}, 32'(bus.owner), 32'(OWNER_NONE));
    endtask

    initial begin
        greset = 1'b1;
        bus.start = 1'b0;
        bus.buzz_a = 1'b0;
        bus.buzz_b = 1'b0;
        bus.answer_valid = 1'b0;
        bus.answer_correct = 1'b0;
        bus.problem = 3'd0;
        step();
        step();
        chk_all_zero("reset");
        greset = 1'b0;
        step();
        chk_all_zero("idle");

        // Round 0: A alone, correct; stray verdict during ARM is ignored.
        start_round(3'd0, 1'b1, 1'b0);
        buzz(1'b1, 1'b0);
        chk("r0_owner", 32'(bus.owner), 32'(OWNER_A));
        chk("r0_state", 32'(bus.state), 32'(ST_ANSWER));
        chk("r0_timer", 32'(bus.timer), ANS_C - 1);
        exp_q.push_back(2'b10);
        bus.answer_valid = 1'b1;
        bus.answer_correct = 1'b1;
        wait_score("r0", 3, took);
        chk("r0_latency", 32'(took), 1);
        chk("r0_idle", 32'(bus.state), 32'(ST_IDLE));

        // Round 1: tie, pointer at A.
        start_round(3'd1, 1'b0, 1'b0);
        buzz(1'b1, 1'b1);
        chk("r1_tie_owner", 32'(bus.owner), 32'(OWNER_A));
        exp_q.push_back(2'b10);
        bus.answer_valid = 1'b1;
        bus.answer_correct = 1'b1;
        wait_score("r1", 3, took);

        // Round 2: tie again, pointer flipped to B.
        start_round(3'd2, 1'b0, 1'b0);
        buzz(1'b1, 1'b1);
        chk("r2_tie_owner", 32'(bus.owner), 32'(OWNER_B));
        exp_q.push_back(2'b01);
        bus.answer_valid = 1'b1;
        bus.answer_correct = 1'b1;
        wait_score("r2", 3, took);

        // Round 3: A wrong, A rebound buzz ignored, B correct.
        start_round(3'd3, 1'b0, 1'b0);
        buzz(1'b1, 1'b0);
        chk("r3_owner_a", 32'(bus.owner), 32'(OWNER_A));
        bus.answer_valid = 1'b1;
        bus.answer_correct = 1'b0;
        step();
        bus.answer_valid = 1'b0;
        chk("r3_rebound_state", 32'(bus.state), 32'(ST_OPEN));
        chk("r3_rebound_owner", 32'(bus.owner), 32'(OWNER_NONE));
        chk("r3_rebound_timer", 32'(bus.timer), OPEN_C - 1);
        chk("r3_no_ready", 32'(bus.ready), 0);
        buzz(1'b1, 1'b0);
        chk("r3_locked_a_state", 32'(bus.state), 32'(ST_OPEN));
        chk("r3_locked_a_owner", 32'(bus.owner), 32'(OWNER_NONE));
        chk("r3_locked_a_timer", 32'(bus.timer), OPEN_C - 2);
        buzz(1'b0, 1'b1);
        chk("r3_owner_b", 32'(bus.owner), 32'(OWNER_B));
        exp_q.push_back(2'b01);
        bus.answer_valid = 1'b1;
        bus.answer_correct = 1'b1;
        wait_score("r3", 3, took);

        // Round 4: nobody buzzes; strobe exactly OPEN_C cycles after OPEN entry.
        start_round(3'd4, 1'b0, 1'b0);
        exp_q.push_back(2'b00);
        wait_score("r4", OPEN_C + 5, took);
        chk("r4_timeout_latency", 32'(took), OPEN_C);

        // Round 5: A times out answering, B rebounds and answers wrong.
        start_round(3'd5, 1'b0, 1'b0);
        buzz(1'b1, 1'b0);
        repeat (ANS_C - 1) step();
        chk("r5_answer_last", 32'(bus.state), 32'(ST_ANSWER));
        chk("r5_timer_zero", 32'(bus.timer), 0);
        step();
        chk("r5_rebound", 32'(bus.state), 32'(ST_OPEN));
        chk("r5_rebound_owner", 32'(bus.owner), 32'(OWNER_NONE));
        buzz(1'b0, 1'b1);
        chk("r5_owner_b", 32'(bus.owner), 32'(OWNER_B));
        exp_q.push_back(2'b00);
        bus.answer_valid = 1'b1;
        bus.answer_correct = 1'b0;
        wait_score("r5", 3, took);
        chk("r5_latency", 32'(took), 1);

        // Round 6: A buzzes in ARM, then tie; reset mid-ANSWER aborts the round.
        start_round(3'd6, 1'b0, 1'b1);
        buzz(1'b1, 1'b1);
`ifdef QUIZ_FALSE_START_EN
        chk("r6_false_start_owner", 32'(bus.owner), 32'(OWNER_B));
`else
        chk("r6_arm_buzz_ignored_owner", 32'(bus.owner), 32'(OWNER_A));
`endif
        repeat (3) step();
        greset = 1'b1;
        step();
        greset = 1'b0;
        chk_all_zero("abort");
        step();
        chk("abort_no_ready", 32'(bus.ready), 0);

        // Round 7: last problem, game ends.
        start_round(3'd7, 1'b0, 1'b0);
        buzz(1'b1, 1'b0);
        exp_q.push_back(2'b10);
        bus.answer_valid = 1'b1;
        bus.answer_correct = 1'b1;
        wait_score("r7", 3, took);
        chk("r7_game_over", 32'(bus.game_over), 1);
        chk("r7_done_state", 32'(bus.state), 32'(ST_DONE));
        chk("r7_busy", 32'(bus.busy), 0);
        bus.problem = 3'd0;
        for (int k = 0; k < 3; k++) begin
            bus.start = 1'b1;
            step();
            bus.start = 1'b0;
            chk("done_start_ready", 32'(bus.ready), 0);
            step();
            chk("done_hold", 32'(bus.state), 32'(ST_DONE));
        end
        greset = 1'b1;
        step();
        greset = 1'b0;
        chk_all_zero("final_reset");
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
